switch_debouncer: RTL and testbench

Input-conditioning stage between the board DIP switches and the lab logic: it synchronizes each raw switch bit into the HSOSC clock domain, debounces it, and presents clean levels to the LED logic and the seven-segment decoder. Each bit is filtered independently. A bit changes only after its synchronized level has held a new value for a programmable number of consecutive cycles. A one-cycle change strobe is provided for downstream sequential logic.

---
 rtl/switch_debouncer.sv | 103 ++++++++++
 tb/tb_switch_debouncer.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/switch_debouncer.sv
// Two-flop synchronizer plus per-bit IDLE/COUNT debounce filter for board switches.
// Outputs are fully registered; s_changed and stable are aligned with s_clean updates.
module switch_debouncer #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 120000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] s_raw,
    output logic [WIDTH-1:0] s_clean,
    output logic             s_changed,
    output logic             stable
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_COUNT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_clean;
    logic             r_changed;
    logic             r_stable;
    state_t           r_state [WIDTH];
    logic [CNT_W-1:0] r_cnt   [WIDTH];

    state_t           w_state_nx [WIDTH];
    logic [CNT_W-1:0] w_cnt_nx   [WIDTH];
    logic [WIDTH-1:0] w_update;
    logic [WIDTH-1:0] w_counting;

    always_comb begin
        w_update   = '0;
        w_counting = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_state_nx[i] = r_state[i];
            w_cnt_nx[i]   = r_cnt[i];
            case (r_state[i])
                S_IDLE: begin
                    if (r_sync2[i] != r_clean[i]) begin
                        w_state_nx[i] = S_COUNT;
                        w_cnt_nx[i]   = CNT_ONE;
                    end else begin
                        w_cnt_nx[i]   = '0;
                    end
                end
                S_COUNT: begin
                    // Any return to the current clean level restarts the full count.
                    if (r_sync2[i] == r_clean[i]) begin
                        w_state_nx[i] = S_IDLE;
                        w_cnt_nx[i]   = '0;
                    end else if (r_cnt[i] == CNT_LAST) begin
                        w_state_nx[i] = S_IDLE;
                        w_cnt_nx[i]   = '0;
                        w_update[i]   = 1'b1;
                    end else begin
                        w_cnt_nx[i]   = r_cnt[i] + CNT_ONE;
                    end
                end
                default: begin
                    w_state_nx[i] = S_IDLE;
                    w_cnt_nx[i]   = '0;
                end
            endcase
            w_counting[i] = (w_state_nx[i] == S_COUNT);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_clean   <= '0;
            r_changed <= 1'b0;
            r_stable  <= 1'b1;
            for (int i = 0; i < WIDTH; i++) begin
                r_state[i] <= S_IDLE;
                r_cnt[i]   <= '0;
            end
        end else begin
            r_sync1   <= s_raw;
            r_sync2   <= r_sync1;
            r_clean   <= (r_clean & ~w_update) | (r_sync2 & w_update);
            // Flags come from next-state so they line up with the new s_clean.
            r_changed <= |w_update;
            r_stable  <= ~|w_counting;
            for (int i = 0; i < WIDTH; i++) begin
                r_state[i] <= w_state_nx[i];
                r_cnt[i]   <= w_cnt_nx[i];
            end
        end
    end

    assign s_clean   = r_clean;
    assign s_changed = r_changed;
    assign stable    = r_stable;

endmodule

// File: tb/tb_switch_debouncer.sv
// Bench for switch_debouncer: directed scenarios plus random holds, checked against
// a sliding-window model (a bit flips once its last D synchronized samples all disagree).
module tb_switch_debouncer;

    localparam int W = 4;
    localparam int D = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] s_raw = '0;
    logic [W-1:0] s_clean;
    logic         s_changed;
    logic         stable;

    always #5 clk = ~clk;

    switch_debouncer #(
        .WIDTH           (W),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .s_raw     (s_raw),
        .s_clean   (s_clean),
        .s_changed (s_changed),
        .stable    (stable)
    );

    int n_cmp = 0;
    int n_err = 0;
    int pulses = 0;

    // q[0] is the raw value captured at the latest edge; q[2] is what the filter sees.
    logic [W-1:0] q[$];
    logic [W-1:0] m_clean;
    logic         m_chg;
    logic         m_stable;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        for (int i = 0; i < D + 2; i++) q.push_back('0);
        m_clean  = '0;
        m_chg    = 1'b0;
        m_stable = 1'b1;
    endtask

    task automatic model_edge(input logic [W-1:0] raw);
        logic [W-1:0] nc;
        bit all_diff;
        q.push_front(raw);
        while (q.size() > D + 2) void'(q.pop_back());
        nc = m_clean;
        for (int b = 0; b < W; b++) begin
            all_diff = 1'b1;
            for (int j = 2; j < D + 2; j++)
                if (q[j][b] == m_clean[b]) all_diff = 1'b0;
            if (all_diff) nc[b] = ~m_clean[b];
        end
        m_chg    = (nc != m_clean);
        m_clean  = nc;
        m_stable = (q[2] == m_clean);
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic step(input logic [W-1:0] raw);
        s_raw = raw;
        @(posedge clk);
        model_edge(raw);
        #1;
        chk("s_clean", s_clean, m_clean);
        chk("s_changed", s_changed, m_chg);
        chk("stable", stable, m_stable);
        if (s_changed === 1'b1) pulses++;
        @(negedge clk);
    endtask

    // Asserts reset between edges and checks outputs before any clock edge arrives.
    task automatic async_reset();
        #2;
        reset = 1'b1;
        #1;
        chk("rst_clean", s_clean, 0);
        chk("rst_changed", s_changed, 0);
        chk("rst_stable", stable, 1);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Holds raw and reports on which edge (capture edge = 1) s_clean reaches it.
    task automatic measure(input string tag, input logic [W-1:0] raw);
        int n;
        bit seen;
        n = 0;
        seen = 1'b0;
        for (int i = 1; i <= 30 && !seen; i++) begin
            step(raw);
            if (s_clean === raw) begin
                seen = 1'b1;
                n = i;
            end
        end
        chk(tag, n, D + 2);
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        chk("init_clean", s_clean, 0);
        chk("init_changed", s_changed, 0);
        chk("init_stable", stable, 1);
        reset = 1'b0;

        // Clean step
        pulses = 0;
        measure("step_latency", 4'b0101);
        repeat (3) step(4'b0101);
        chk("step_pulses", pulses, 1);

        // Bounce on bit 0
        async_reset();
        pulses = 0;
        repeat (5) step(4'b0001);
        step(4'b0000);
        measure("bounce_latency", 4'b0001);
        repeat (3) step(4'b0001);
        chk("bounce_pulses", pulses, 1);

        // Short pulse on bit 3
        pulses = 0;
        repeat (D - 1) step(4'b1001);
        repeat (15) step(4'b0001);
        chk("short_pulses", pulses, 0);
        chk("short_clean", s_clean, 4'b0001);

        // Simultaneous bits 1,2 then bit 3 one cycle later
        pulses = 0;
        step(4'b0111);
        repeat (14) step(4'b1111);
        chk("simul_pulses", pulses, 2);

        // Reset mid-count
        async_reset();
        repeat (4) step(4'b1111);
        async_reset();
        measure("rstmid_latency", 4'b1111);
        repeat (2) step(4'b1111);

        // Falling edge on bit 2
        pulses = 0;
        measure("fall_latency", 4'b1011);
        repeat (3) step(4'b1011);
        chk("fall_pulses", pulses, 1);

        // Random holds of varying length, with occasional resets
        for (int seg = 0; seg < 250; seg++) begin
            logic [W-1:0] v;
            int len;
            v = W'($urandom_range(0, 15));
            len = $urandom_range(1, 14);
            if ($urandom_range(0, 40) == 0) async_reset();
            for (int k = 0; k < len; k++) step(v);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
